// File: rtl/apb_regbank_completer.sv
// apb_regbank_completer: APB3 completer with a byte-wide register bank, programmable wait states
// and an error response for addresses beyond the bank.
module apb_regbank_completer #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  setup, rise, r_write, r_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    // With zero wait states the response is produced from the setup-phase inputs directly.
    always_comb begin
        setup   = PSEL && !PENABLE;
        r_addr  = setup ? PADDR : addr;
        r_write = setup ? PWRITE : write;
        r_err   = {1'b0, r_addr} >= (ADDR_WIDTH + 1)'(DEPTH);
        r_data  = (r_write || r_err) ? '0 : mem[r_addr[IW-1:0]];
        rise    = setup ? (WAIT_CYCLES == 0) : (state == ACCESS && PSEL && !PREADY && cnt == 4'd1);
    end
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            addr    <= '0;
            write   <= 1'b0;
            wdata   <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            // PSLVERR is still high at completion for an out-of-range address, which blocks the commit.
            if (PSEL && PENABLE && PREADY && write && !PSLVERR) mem[addr[IW-1:0]] <= wdata;
            if (setup) begin
                state <= ACCESS;
                addr  <= PADDR;
                write <= PWRITE;
                wdata <= PWDATA;
                cnt   <= 4'(WAIT_CYCLES);
            end else if (state == ACCESS && (!PSEL || PREADY)) begin
                state <= IDLE;
            end else if (state == ACCESS) begin
                cnt <= cnt - 4'd1;
            end
            PREADY  <= rise;
            PSLVERR <= rise && r_err;
            PRDATA  <= rise ? r_data : '0;
        end
    end
endmodule

// File: tb/tb_apb_regbank_completer.sv
// tb_apb_regbank_completer: four completers with WAIT_CYCLES 1, 0, 3, 15 on a shared bus,
// each selected by its own PSEL and checked against an array model of the register bank.
module tb_apb_regbank_completer;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] psel;
    logic       penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata [4];
    logic       pready [4];
    logic       pslverr [4];
    logic [7:0] model [4][64];
    int         wait_of [4] = '{1, 0, 3, 15};
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        apb_regbank_completer #(
            .WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 3 : 15)
        ) u_dut (
            .PCLK(clk),
            .PRESET(rst),
            .PSEL(psel[g]),
            .PENABLE(penable),
            .PWRITE(pwrite),
            .PADDR(paddr),
            .PWDATA(pwdata),
            .PRDATA(prdata[g]),
            .PREADY(pready[g]),
            .PSLVERR(pslverr[g])
        );
    end

    // got = {prdata at ready, pslverr at ready, pready after completion edge, waits before ready}
    task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                        output logic [17:0] got);
        int w = 0;
        psel = 4'b0;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = a;
        pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        while (pready[d] !== 1'b1 && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        got[17:10] = prdata[d];
        got[9] = pslverr[d];
        @(posedge clk); #1;
        got[8] = pready[d];
        got[7:0] = 8'(w);
        psel = 4'b0;
        penable = 1'b0;
    endtask

    function automatic logic [17:0] expect_of(int d, logic wr, logic [7:0] a);
        logic bad = a >= 8'd64;
        return {(wr || bad) ? 8'h00 : model[d][a[5:0]], bad, 1'b0, 8'(wait_of[d])};
    endfunction

    task automatic mw(int d, logic [7:0] a, logic [7:0] wd);
        if (a < 8'd64) model[d][a[5:0]] = wd;
    endtask

    task automatic clear_model();
        for (int d = 0; d < 4; d++)
            for (int a = 0; a < 64; a++) model[d][a] = 8'h00;
    endtask

    task automatic test_reset();
        logic [17:0] got;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if ({pready[d], pslverr[d], prdata[d]} !== 10'b0) begin
                failures++;
                $display("FAIL reset_state dut%0d got ready=%b err=%b rd=%h need 0 0 00", d, pready[d], pslverr[d], prdata[d]);
            end
        end
        xfer(0, 1'b1, 8'd20, 8'h3C, got);
        mw(0, 8'd20, 8'h3C);
        psel = 4'b0001;
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = 8'd20;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (pready[0] !== 1'b1 || prdata[0] !== 8'h3C) begin
            failures++;
            $display("FAIL pre_reset_read got ready=%b rd=%h need 1 3c", pready[0], prdata[0]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pready[0], pslverr[0], prdata[0]} !== 10'b0) begin
            failures++;
            $display("FAIL reset_async got ready=%b err=%b rd=%h need 0 0 00", pready[0], pslverr[0], prdata[0]);
        end
        psel = 4'b0;
        penable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        for (int a = 0; a < 64; a++) begin
            xfer(0, 1'b0, 8'(a), 8'h00, got);
            checks++;
            if (got !== {8'h00, 1'b0, 1'b0, 8'd1}) begin
                failures++;
                $display("FAIL reset_cleared addr=%0d got %h need %h", a, got, {8'h00, 1'b0, 1'b0, 8'd1});
            end
        end
    endtask

    task automatic test_write_read();
        logic [17:0] got;
        logic [4:0]  wr_t = 5'b00011;
        int          a_t [5] = '{5, 10, 5, 10, 50};
        int          d_t [5] = '{55, 99, 0, 0, 0};
        int          r_t [5] = '{0, 0, 55, 99, 0};
        for (int i = 0; i < 5; i++) begin
            xfer(0, wr_t[i], 8'(a_t[i]), 8'(d_t[i]), got);
            if (wr_t[i]) mw(0, 8'(a_t[i]), 8'(d_t[i]));
            checks++;
            if (got !== {8'(r_t[i]), 1'b0, 1'b0, 8'd1}) begin
                failures++;
                $display("FAIL write_read step%0d addr=%0d got %h need %h", i, a_t[i], got, {8'(r_t[i]), 1'b0, 1'b0, 8'd1});
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [17:0] got;
        logic [5:0]  wr_t = 6'b000111;
        int          a_t [6] = '{6, 63, 70, 70, 6, 63};
        int          d_t [6] = '{102, 63, 123, 0, 0, 0};
        int          r_t [6] = '{0, 0, 0, 0, 102, 63};
        logic [5:0]  e_t = 6'b001100;
        for (int i = 0; i < 6; i++) begin
            xfer(0, wr_t[i], 8'(a_t[i]), 8'(d_t[i]), got);
            if (wr_t[i]) mw(0, 8'(a_t[i]), 8'(d_t[i]));
            checks++;
            if (got !== {8'(r_t[i]), e_t[i], 1'b0, 8'd1}) begin
                failures++;
                $display("FAIL out_of_range step%0d addr=%0d got %h need %h", i, a_t[i], got, {8'(r_t[i]), e_t[i], 1'b0, 8'd1});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] got;
        xfer(1, 1'b1, 8'd63, 8'd200, got);
        mw(1, 8'd63, 8'd200);
        checks++;
        if (got !== {8'd0, 1'b0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL zero_wait_write got %h need %h", got, {8'd0, 1'b0, 1'b0, 8'd0});
        end
        xfer(1, 1'b0, 8'd63, 8'd0, got);
        checks++;
        if (got !== {8'd200, 1'b0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL zero_wait_read got %h need %h", got, {8'd200, 1'b0, 1'b0, 8'd0});
        end
    endtask

    task automatic test_abort();
        logic [17:0] got;
        xfer(2, 1'b1, 8'd3, 8'd11, got);
        mw(2, 8'd3, 8'd11);
        checks++;
        if (got !== {8'd0, 1'b0, 1'b0, 8'd3}) begin
            failures++;
            $display("FAIL abort_prewrite got %h need %h", got, {8'd0, 1'b0, 1'b0, 8'd3});
        end
        psel = 4'b0100;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 8'd3;
        pwdata = 8'd77;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (pready[2] !== 1'b0) begin
            failures++;
            $display("FAIL abort_access got ready=%b need 0", pready[2]);
        end
        psel = 4'b0;
        penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (pready[2] !== 1'b0) begin
                failures++;
                $display("FAIL abort_idle cycle%0d got ready=%b need 0", i, pready[2]);
            end
        end
        xfer(2, 1'b0, 8'd3, 8'd0, got);
        checks++;
        if (got !== {8'd11, 1'b0, 1'b0, 8'd3}) begin
            failures++;
            $display("FAIL abort_readback got %h need %h", got, {8'd11, 1'b0, 1'b0, 8'd3});
        end
    endtask

    task automatic test_wait_sweep();
        logic [17:0] got;
        xfer(3, 1'b1, 8'd0, 8'hA5, got);
        mw(3, 8'd0, 8'hA5);
        checks++;
        if (got !== {8'd0, 1'b0, 1'b0, 8'd15}) begin
            failures++;
            $display("FAIL sweep_write got %h need %h", got, {8'd0, 1'b0, 1'b0, 8'd15});
        end
        xfer(3, 1'b0, 8'd0, 8'd0, got);
        checks++;
        if (got !== {8'hA5, 1'b0, 1'b0, 8'd15}) begin
            failures++;
            $display("FAIL sweep_read got %h need %h", got, {8'hA5, 1'b0, 1'b0, 8'd15});
        end
    endtask

    task automatic test_random();
        logic [17:0] got, exp;
        logic        wr;
        logic [7:0]  a, wd;
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 20; i++) begin
                wr = 1'($urandom_range(0, 1));
                a = 8'($urandom_range(0, 79));
                wd = 8'($urandom);
                exp = expect_of(d, wr, a);
                xfer(d, wr, a, wd, got);
                if (wr) mw(d, a, wd);
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL random dut%0d wr=%b addr=%0d got %h need %h", d, wr, a, got, exp);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        psel = 4'b0;
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = 8'h00;
        pwdata = 8'h00;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_abort();
        test_wait_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
